// File: rtl/usart_pkg.sv
// Shared types and line levels for the USART transmit arbiter.
package usart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/usart_baud_tick.sv
// Bit-period counter: counts 0..CLK_PER_BIT-1 and flags the last cycle of each bit.
module usart_baud_tick #(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter between two byte producers feeding one 8N1 transmitter.
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       REQ0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       TX_OUT,
  output logic       BUSY,
  output logic       GNT
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 win;
  logic                 bit_end;
  logic                 restart;

  // Counter is held at zero in IDLE so the first bit of a frame gets a full period.
  assign restart = (state_q == IDLE) || (state_d != state_q);

  usart_baud_tick #(
    .CLK_PER_BIT(CLK_PER_BIT)
  ) u_baud (
    .clk    (CLK),
    .clr    (CLR),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          win     = (REQ0 && REQ1) ? ~last_q : REQ1;
          gnt_d   = win;
          last_d  = win;
          shreg_d = win ? DATA1 : DATA0;
          ack0_d  = ~win;
          ack1_d  = win;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is derived from the next state so TX_OUT stays a plain register.
    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shreg_d[0];
      STOP:    tx_d = STOP_LEVEL;
      default: tx_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign GNT    = gnt_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Self-checking bench: frame-timeline reference model plus directed and random traffic.
module tb_usart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       ack0, ack1, tx, busy, gnt;

  int vectors = 0;
  int miscompares = 0;

  usart_tx_arbiter #(.CLK_PER_BIT(CPB)) dut (
    .CLK(clk), .CLR(clr),
    .REQ0(req0), .DATA0(d0), .ACK0(ack0),
    .REQ1(req1), .DATA1(d1), .ACK1(ack1),
    .TX_OUT(tx), .BUSY(busy), .GNT(gnt)
  );

  always #5 clk = ~clk;

  // Reference model: age = cycles since the grant edge (1..FRAME while a frame is on the line).
  int         m_age = 0;
  logic [7:0] m_byte = '0;
  logic       m_gnt = 1'b0, m_last = 1'b1, m_ack0 = 1'b0, m_ack1 = 1'b0;
  bit         checking = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_age = 0; m_gnt = 1'b0; m_last = 1'b1; m_ack0 = 1'b0; m_ack1 = 1'b0;
      checking = 1;
    end else begin
      m_ack0 = 1'b0; m_ack1 = 1'b0;
      if ((m_age < 1 || m_age > FRAME) && (req0 || req1)) begin
        m_gnt  = (req0 && req1) ? !m_last : req1;
        m_last = m_gnt;
        m_byte = m_gnt ? d1 : d0;
        if (m_gnt) m_ack1 = 1'b1; else m_ack0 = 1'b1;
        m_age = 1;
      end else if (m_age >= 1 && m_age <= FRAME) begin
        m_age = m_age + 1;
      end
    end
  end

  function automatic logic model_tx();
    int b;
    if (m_age < 1 || m_age > FRAME) return 1'b1;
    b = (m_age - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  always @(negedge clk) begin
    logic [4:0] got, want;
    if (checking) begin
      got  = {tx, busy, gnt, ack0, ack1};
      want = {model_tx(), (m_age >= 1 && m_age <= FRAME), m_gnt, m_ack0, m_ack1};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t tx/busy/gnt/ack0/ack1 got %b want %b", $time, got, want);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_ack(input int who, output bit found);
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if ((who == 0 && ack0) || (who == 1 && ack1)) begin
        found = 1;
        break;
      end
    end
    if (!found) check($sformatf("ack%0d_timeout", who), 0, 1);
  endtask

  task automatic request(input int who, input logic [7:0] b);
    bit f;
    @(posedge clk); #1;
    if (who == 0) begin req0 = 1'b1; d0 = b; end
    else          begin req1 = 1'b1; d1 = b; end
    wait_ack(who, f);
    @(posedge clk); #1;
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
  endtask

  initial begin
    bit         f;
    int         t0, busycnt, lowcnt;
    logic [9:0] bits;
    logic [9:0] want_a5;
    logic [3:0] gseq;
    logic [3:0] want_gseq;

    // S1: single requester, 0xA5
    do_reset();
    fork request(0, 8'hA5); join_none
    wait_ack(0, f);
    check("s1_gnt", gnt, 0);
    busycnt = 0; bits = '0;
    for (int i = 0; i < FRAME; i++) begin
      if (i % CPB == 2) bits[i / CPB] = tx;
      busycnt += busy;
      @(negedge clk);
    end
    want_a5 = 10'b1101001010;
    check("s1_bits", bits, want_a5);
    check("s1_busy_cycles", busycnt, 40);
    check("s1_tx_after", tx, 1);
    check("s1_busy_after", busy, 0);

    // S2: simultaneous requests, tie goes to 0 first
    do_reset();
    fork
      request(0, 8'h11);
      request(1, 8'h22);
    join_none
    wait_ack(0, f);
    t0 = $time / 10;
    check("s2_first_gnt", gnt, 0);
    wait_ack(1, f);
    check("s2_ack_spacing", $time / 10 - t0, 41);
    check("s2_second_gnt", gnt, 1);
    repeat (45) @(negedge clk);

    // S3: both held continuously, grants alternate
    do_reset();
    @(posedge clk); #1;
    req0 = 1'b1; d0 = 8'h55; req1 = 1'b1; d1 = 8'hAA;
    for (int k = 0; k < 4; k++) begin
      f = 0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (ack0 || ack1) begin f = 1; break; end
      end
      if (!f) check("s3_ack_timeout", 0, 1);
      gseq[k] = gnt;
    end
    want_gseq = 4'b1010;
    check("s3_gnt_seq", gseq, want_gseq);
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    repeat (45) @(negedge clk);

    // S4: short REQ1 pulse mid-frame is ignored
    do_reset();
    fork request(0, 8'h3C); join_none
    wait_ack(0, f);
    repeat (8) @(negedge clk);
    @(posedge clk); #1 req1 = 1'b1; d1 = 8'hFF;
    repeat (3) @(posedge clk);
    #1 req1 = 1'b0;
    lowcnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lowcnt += ack1;
    end
    check("s4_no_ack1", lowcnt, 0);
    check("s4_tx_idle", tx, 1);

    // S5: CLR mid-frame together with a new REQ1
    do_reset();
    fork request(0, 8'hC3); join_none
    wait_ack(0, f);
    repeat (14) @(negedge clk);
    @(posedge clk); #1 clr = 1'b1; req1 = 1'b1; d1 = 8'h5A;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("s5_tx", tx, 1);
    check("s5_busy", busy, 0);
    check("s5_gnt", gnt, 0);
    check("s5_no_ack", {ack0, ack1}, 0);
    wait_ack(1, f);
    check("s5_gnt1", gnt, 1);
    @(posedge clk); #1 req1 = 1'b0;
    repeat (45) @(negedge clk);

    // S6: 0x00 from requester 1
    do_reset();
    fork request(1, 8'h00); join_none
    wait_ack(1, f);
    lowcnt = 0; busycnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i < 36) lowcnt += (tx == 1'b0);
      else        busycnt += (tx == 1'b1);
      @(negedge clk);
    end
    check("s6_low_cycles", lowcnt, 36);
    check("s6_stop_cycles", busycnt, 4);

    // Random traffic, occasional reset; the per-cycle model does the checking
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      clr = ($urandom_range(0, 499) == 0);
      if (req0 && ack0) begin
        req0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom);
      end else if (!req0 && $urandom_range(0, 7) == 0) begin
        req0 = 1'b1; d0 = 8'($urandom);
      end
      if (req1 && ack1) begin
        req1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom);
      end else if (!req1 && $urandom_range(0, 7) == 0) begin
        req1 = 1'b1; d1 = 8'($urandom);
      end
    end
    @(posedge clk); #1 clr = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (50) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
